// File: rtl/oled_pkg.sv
// ============================================================================
// oled_pkg : shared types, DATA field indices and SSD1331 command bytes
// Revision : 1.0
// ============================================================================
`default_nettype none

package oled_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        SHIFT    = 3'd2,
        HOLD     = 3'd3,
        DONE     = 3'd4,
        WAIT_LOW = 3'd5
    } state_t;

    localparam int DATA_W   = 10;
    localparam int DC_BIT   = 8;
    localparam int BYTE_MSB = 7;

    localparam logic [7:0] CMD_SET_CONTRAST_A  = 8'h81;
    localparam logic [7:0] CMD_SET_CONTRAST_B  = 8'h82;
    localparam logic [7:0] CMD_SET_CONTRAST_C  = 8'h83;
    localparam logic [7:0] CMD_MASTER_CURRENT  = 8'h87;
    localparam logic [7:0] CMD_REMAP           = 8'hA0;
    localparam logic [7:0] CMD_START_LINE      = 8'hA1;
    localparam logic [7:0] CMD_DISPLAY_OFFSET  = 8'hA2;
    localparam logic [7:0] CMD_NORMAL_DISPLAY  = 8'hA4;
    localparam logic [7:0] CMD_MULTIPLEX       = 8'hA8;
    localparam logic [7:0] CMD_MASTER_CONFIG   = 8'hAD;
    localparam logic [7:0] CMD_DISPLAY_OFF     = 8'hAE;
    localparam logic [7:0] CMD_DISPLAY_ON      = 8'hAF;
    localparam logic [7:0] CMD_POWER_SAVE      = 8'hB0;
    localparam logic [7:0] CMD_PHASE_ADJUST    = 8'hB1;
    localparam logic [7:0] CMD_CLOCK_DIV       = 8'hB3;
    localparam logic [7:0] CMD_PRECHARGE_LEVEL = 8'hBB;
    localparam logic [7:0] CMD_VCOMH           = 8'hBE;

endpackage

`default_nettype wire

// File: rtl/oled_spi_tick.sv
// ============================================================================
// oled_spi_tick : CLK_DIV half-period counter, ticks on the last cycle of a phase
// Revision      : 1.0
// ============================================================================
`default_nettype none

module oled_spi_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic restart,
    output logic tick
);

    localparam int                CNT_W = $clog2(CLK_DIV) + 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            count <= '0;
        else if (restart || count == LAST)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign tick = (count == LAST);

endmodule

`default_nettype wire

// File: rtl/oled_spi_writer.sv
// ============================================================================
// oled_spi_writer : one 10-bit word per handshake, shifted out MSB-first, SPI mode 3
// Revision        : 1.0
// ============================================================================
`default_nettype none

module oled_spi_writer
    import oled_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              WRITE_START,
    input  logic [DATA_W-1:0] DATA,
    output logic              WRITE_DONE,
    output logic              BUSY,
    output logic              CS_N,
    output logic              DC,
    output logic              SCLK,
    output logic              SDIN
);

    state_t      state, state_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic [2:0]  bit_cnt, bit_cnt_nxt;
    logic        write_done_nxt, busy_nxt, cs_n_nxt, dc_nxt, sclk_nxt, sdin_nxt;
    logic        tick;
    logic        restart;
    logic        unused_reserved;

    assign unused_reserved = DATA[DATA_W-1];
    assign restart         = (state == IDLE);

    oled_spi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            WRITE_DONE <= 1'b0;
            BUSY       <= 1'b0;
            CS_N       <= 1'b1;
            DC         <= 1'b0;
            SCLK       <= 1'b1;
            SDIN       <= 1'b0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            bit_cnt    <= bit_cnt_nxt;
            WRITE_DONE <= write_done_nxt;
            BUSY       <= busy_nxt;
            CS_N       <= cs_n_nxt;
            DC         <= dc_nxt;
            SCLK       <= sclk_nxt;
            SDIN       <= sdin_nxt;
        end
    end

    // The 8th rise is taken while SCLK is low on bit 7; its high phase counts as HOLD.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (WRITE_START) state_nxt = SETUP;
            SETUP:    if (tick) state_nxt = SHIFT;
            SHIFT:    if (tick && !SCLK && bit_cnt == 3'd7) state_nxt = HOLD;
            HOLD:     if (tick) state_nxt = DONE;
            DONE:     state_nxt = WAIT_LOW;
            WAIT_LOW: if (!WRITE_START) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        shreg_nxt      = shreg;
        bit_cnt_nxt    = bit_cnt;
        write_done_nxt = 1'b0;
        busy_nxt       = BUSY;
        cs_n_nxt       = CS_N;
        dc_nxt         = DC;
        sclk_nxt       = SCLK;
        sdin_nxt       = SDIN;
        case (state)
            IDLE: begin
                if (WRITE_START) begin
                    shreg_nxt   = DATA[BYTE_MSB:0];
                    bit_cnt_nxt = 3'd0;
                    busy_nxt    = 1'b1;
                    cs_n_nxt    = 1'b0;
                    dc_nxt      = DATA[DC_BIT];
                    sdin_nxt    = DATA[BYTE_MSB];
                    sclk_nxt    = 1'b1;
                end
            end
            SETUP: begin
                if (tick) sclk_nxt = 1'b0;
            end
            SHIFT: begin
                if (tick) begin
                    if (!SCLK) begin
                        sclk_nxt = 1'b1;
                    end else begin
                        sclk_nxt    = 1'b0;
                        shreg_nxt   = {shreg[BYTE_MSB-1:0], 1'b0};
                        sdin_nxt    = shreg[BYTE_MSB-1];
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    cs_n_nxt       = 1'b1;
                    write_done_nxt = 1'b1;
                end
            end
            DONE: begin
                write_done_nxt = 1'b0;
            end
            WAIT_LOW: begin
                if (!WRITE_START) busy_nxt = 1'b0;
            end
            default: begin
                busy_nxt = 1'b0;
                cs_n_nxt = 1'b1;
                sclk_nxt = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire
